// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester handshakes and the single-port
// data memory connection that the arbiter sits between.
//   slave  : arbiter side (takes requests, drives the memory)
//   master : environment side (requesters plus the memory itself)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              err0;
    logic              err1;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] rs2;
    logic [DATA_W-1:0] read_data_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1, err0, err1,
        output mem_read, mem_write, r, rs2,
        input  read_data_out
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1, err0, err1,
        input  mem_read, mem_write, r, rs2,
        output read_data_out
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between port 0 (core LSU)
// and port 1 (debug/DMA loader). One access at a time walks IDLE -> ACCESS ->
// ACK; the winner gets a one-cycle ack with its read data.
// Optional feature macro: DMEM_ARB_ALIGN_CHK_EN -- when defined, a winning
// request whose byte address is not word aligned skips the memory access and
// is acked with err set.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_id;
    logic              r_we;
    logic              r_last;
    logic              r_memRead;
    logic              r_memWrite;
    logic              r_ack0;
    logic              r_ack1;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    logic              r_err0;
    logic              r_err1;
`endif

    logic              w_anyReq;
    logic              w_grant1;
    logic              w_winWe;
    logic [ADDR_W-1:0] w_winAddr;
    logic [DATA_W-1:0] w_winWdata;
    logic              w_reject;

    // Pick the winner among live requests and select its fields.
    always_comb begin
        w_anyReq = bus.req0 | bus.req1;
        if (FIXED_PRIO != 0) begin
            w_grant1 = bus.req1 & ~bus.req0;
        end else begin
            w_grant1 = bus.req1 & (~bus.req0 | ~r_last);
        end
        w_winWe    = w_grant1 ? bus.we1    : bus.we0;
        w_winAddr  = w_grant1 ? bus.addr1  : bus.addr0;
        w_winWdata = w_grant1 ? bus.wdata1 : bus.wdata0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
        w_reject   = (w_winAddr[1:0] != 2'b00);
`else
        w_reject   = 1'b0;
`endif
    end

    // Access sequencer: latch the winner in IDLE, run one memory cycle, ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_id       <= 1'b0;
            r_we       <= 1'b0;
            r_last     <= 1'b1;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_id    <= w_grant1;
                        r_we    <= w_winWe;
                        r_addr  <= w_winAddr;
                        r_wdata <= w_winWdata;
                        if (w_reject) begin
                            r_state <= S_ACK;
                            r_ack0  <= ~w_grant1;
                            r_ack1  <= w_grant1;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                            r_err0  <= ~w_grant1;
                            r_err1  <= w_grant1;
`endif
                        end else begin
                            r_state    <= S_ACCESS;
                            r_memWrite <= w_winWe;
                            r_memRead  <= ~w_winWe;
                        end
                    end
                end
                S_ACCESS: begin
                    r_memRead  <= 1'b0;
                    r_memWrite <= 1'b0;
                    if (!r_we) begin
                        if (r_id) begin
                            r_rdata1 <= bus.read_data_out;
                        end else begin
                            r_rdata0 <= bus.read_data_out;
                        end
                    end
                    r_ack0  <= ~r_id;
                    r_ack1  <= r_id;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
`endif
                    r_last  <= r_id;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory strobes and acks are masked by rst so a reset mid-access can
    // neither commit a write nor show a partial handshake.
    assign bus.mem_read  = r_memRead  & ~rst;
    assign bus.mem_write = r_memWrite & ~rst;
    assign bus.r         = r_addr;
    assign bus.rs2       = r_wdata;
    assign bus.ack0      = r_ack0 & ~rst;
    assign bus.ack1      = r_ack1 & ~rst;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign bus.err0      = r_err0 & ~rst;
    assign bus.err1      = r_err1 & ~rst;
`else
    assign bus.err0      = 1'b0;
    assign bus.err1      = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. Instance A is
// round-robin, instance B uses fixed priority. Each instance talks to its own
// 64-word behavioural memory; expectations come from a transaction-level model.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic memInit;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifA ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifB ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA.slave)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB.slave)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memories: combinational read, write on posedge.
    logic [31:0] memA [64];
    logic [31:0] memB [64];

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 64; i++) memA[i] <= 32'hA500_0000 | 32'(i);
        end else if (ifA.mem_write) begin
            memA[ifA.r[7:2]] <= ifA.rs2;
        end
    end

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 64; i++) memB[i] <= 32'hA500_0000 | 32'(i);
        end else if (ifB.mem_write) begin
            memB[ifB.r[7:2]] <= ifB.rs2;
        end
    end

    assign ifA.read_data_out = memA[ifA.r[7:2]];
    assign ifB.read_data_out = memB[ifB.r[7:2]];

    // Reference model state (transaction level).
    logic [31:0] refMem [64];
    logic [31:0] refRd  [2];
    int          modelLast;

    int nChecks = 0;
    int nPass   = 0;

    // Watchdog: never let the run hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    function automatic int wordOf(input logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    function automatic bit isReject(input logic [31:0] a);
`ifdef DMEM_ARB_ALIGN_CHK_EN
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelReset();
        modelLast = 1;
        refRd[0]  = 32'h0;
        refRd[1]  = 32'h0;
    endtask

    task automatic modelAccess(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (isReject(a)) return;
        if (we) refMem[wordOf(a)] = d;
        else    refRd[p]          = refMem[wordOf(a)];
    endtask

    task automatic applyStimulus(input bit p, input bit en, input bit we,
                                 input logic [31:0] a, input logic [31:0] d);
        if (!p) begin
            ifA.req0 = en; ifA.we0 = we; ifA.addr0 = a; ifA.wdata0 = d;
        end else begin
            ifA.req1 = en; ifA.we1 = we; ifA.addr1 = a; ifA.wdata1 = d;
        end
    endtask

    task automatic releaseReq(input int p);
        if (p == 0) ifA.req0 = 1'b0;
        else        ifA.req1 = 1'b0;
    endtask

    task automatic resetDut(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    // Issue one or two simultaneous requests on instance A and check every ack
    // against the model: ordering, cycle of ack, err, both rdata, strobes.
    task automatic runPair(input bit en0, input bit en1, input bit we0, input bit we1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input string tag,
                           output logic [31:0] rdOut0, output logic [31:0] rdOut1);
        bit          en [2];
        bit          we [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        bit          rej [2];
        bit          done [2];
        bit          drop [2];
        int          expT [2];
        int          first, second, wrExp, rdExp, wrCnt, rdCnt;
        logic        ackNow;
        en[0] = en0; en[1] = en1; we[0] = we0; we[1] = we1;
        ad[0] = a0;  ad[1] = a1;  wd[0] = d0;  wd[1] = d1;
        rdOut0 = ifA.rdata0;
        rdOut1 = ifA.rdata1;
        wrExp = 0; rdExp = 0; wrCnt = 0; rdCnt = 0;
        for (int p = 0; p < 2; p++) begin
            rej[p] = isReject(ad[p]); done[p] = 1'b0; drop[p] = 1'b0; expT[p] = 0;
            if (en[p] && !rej[p]) begin
                if (we[p]) wrExp++;
                else       rdExp++;
            end
        end
        if (en0 && en1) first = (modelLast == 1) ? 0 : 1;
        else            first = en0 ? 0 : 1;
        second = 1 - first;
        expT[first] = rej[first] ? 1 : 2;
        if (en0 && en1) expT[second] = expT[first] + 2 + (rej[second] ? 0 : 1);
        applyStimulus(1'b0, en0, we0, a0, d0);
        applyStimulus(1'b1, en1, we1, a1, d1);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (drop[p]) begin releaseReq(p); drop[p] = 1'b0; end
            end
            if ((!en0 || done[0]) && (!en1 || done[1])) break;
            @(negedge clk);
            if (ifA.mem_write) wrCnt++;
            if (ifA.mem_read)  rdCnt++;
            for (int p = 0; p < 2; p++) begin
                ackNow = (p == 1) ? ifA.ack1 : ifA.ack0;
                if (ackNow) begin
                    if (!en[p] || done[p]) begin
                        checkBit($sformatf("%s_spuriousAck%0d", tag, p), 1'b1, 1'b0);
                    end else begin
                        done[p] = 1'b1;
                        drop[p] = 1'b1;
                        checkOutput($sformatf("%s_ackCycle%0d", tag, p), 32'(c), 32'(expT[p]));
                        modelAccess(p, we[p], ad[p], wd[p]);
                        checkBit($sformatf("%s_err%0d", tag, p),
                                 (p == 1) ? ifA.err1 : ifA.err0, rej[p]);
                        checkOutput($sformatf("%s_rdata0", tag), ifA.rdata0, refRd[0]);
                        checkOutput($sformatf("%s_rdata1", tag), ifA.rdata1, refRd[1]);
                        if (p == 0) rdOut0 = ifA.rdata0;
                        else        rdOut1 = ifA.rdata1;
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (en[p] && !done[p]) begin
                checkBit($sformatf("%s_timeout%0d", tag, p), 1'b0, 1'b1);
                releaseReq(p);
            end
        end
        checkOutput({tag, "_memWritePulses"}, 32'(wrCnt), 32'(wrExp));
        checkOutput({tag, "_memReadPulses"},  32'(rdCnt), 32'(rdExp));
        modelLast = (en0 && en1) ? second : first;
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs [9];

    // Main test sequence.
    initial begin
        logic [31:0] rd0, rd1;
        int          k, prevC, nAck0, nAck1, waitC;
        bit          seen, expP, gotP;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0024, 32'h2222_2222, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h1111_1111};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,         32'h2222_2222};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0120, 32'h3333_3333, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h3333_3333};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hCAFE_F00D};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0011};

        for (int i = 0; i < 64; i++) refMem[i] = 32'hA500_0000 | 32'(i);
        ifA.req0 = 0; ifA.req1 = 0; ifA.we0 = 0; ifA.we1 = 0;
        ifA.addr0 = 0; ifA.addr1 = 0; ifA.wdata0 = 0; ifA.wdata1 = 0;
        ifB.req0 = 0; ifB.req1 = 0; ifB.we0 = 0; ifB.we1 = 0;
        ifB.addr0 = 0; ifB.addr1 = 0; ifB.wdata0 = 0; ifB.wdata1 = 0;
        rst = 1'b1;
        memInit = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        memInit = 1'b0;
        rst = 1'b0;
        modelReset();

        $display("[TB] reset state");
        @(negedge clk);
        checkBit("rst_ack0", ifA.ack0, 1'b0);
        checkBit("rst_ack1", ifA.ack1, 1'b0);
        checkBit("rst_memWrite", ifA.mem_write, 1'b0);
        checkBit("rst_memRead", ifA.mem_read, 1'b0);
        checkOutput("rst_rdata0", ifA.rdata0, 32'h0);
        checkOutput("rst_rdata1", ifA.rdata1, 32'h0);
        @(posedge clk);
        #1;

        $display("[TB] reset in the middle of a write");
        runPair(1, 1, 0, 0, 32'h0C, 32'h14, 0, 0, "t1pre", rd0, rd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkBit("t1_memWriteInRst", ifA.mem_write, 1'b0);
            checkBit("t1_ack0InRst", ifA.ack0, 1'b0);
            @(posedge clk);
            #1;
        end
        releaseReq(0);
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("t1_rdata0", ifA.rdata0, 32'h0);
        checkOutput("t1_rdata1", ifA.rdata1, 32'h0);
        checkBit("t1_ack0", ifA.ack0, 1'b0);
        @(posedge clk);
        #1;
        runPair(1, 0, 0, 0, 32'h10, 0, 0, 0, "t1post", rd0, rd1);
        checkOutput("t1_wordUnchanged", rd0, 32'hA500_0004);

        $display("[TB] port0 write then read");
        runPair(1, 0, 1, 0, 32'h08, 0, 32'hDEAD_BEEF, 0, "t2w", rd0, rd1);
        runPair(1, 0, 0, 0, 32'h08, 0, 0, 0, "t2r", rd0, rd1);
        checkOutput("t2_rdata0", rd0, 32'hDEAD_BEEF);

        $display("[TB] simultaneous requests after reset");
        runPair(1, 1, 1, 1, 32'h00, 32'h04, 32'd17, 32'd9, "t3w", rd0, rd1);
        resetDut(2);
        runPair(1, 1, 0, 0, 32'h00, 32'h04, 0, 0, "t3r", rd0, rd1);
        checkOutput("t3_rdata0", rd0, 32'd17);
        checkOutput("t3_rdata1", rd1, 32'd9);

        $display("[TB] round robin with both held");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h00, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h04, 0);
        k = 0;
        prevC = 0;
        for (int c = 1; c <= 40 && k < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifA.ack0 || ifA.ack1) begin
                checkBit("rr_singleAck", ifA.ack0 & ifA.ack1, 1'b0);
                gotP = ifA.ack1;
                expP = (modelLast == 1) ? 1'b0 : 1'b1;
                checkBit($sformatf("rr_port%0d", k), gotP, expP);
                checkOutput($sformatf("rr_cycle%0d", k), 32'(c), (k == 0) ? 32'd2 : 32'(prevC + 3));
                modelLast = int'(expP);
                modelAccess(int'(expP), 1'b0, expP ? 32'h04 : 32'h00, 0);
                checkOutput("rr_rdata", expP ? ifA.rdata1 : ifA.rdata0, refRd[expP]);
                prevC = c;
                k++;
            end
        end
        if (k < 6) checkOutput("rr_timeout", 32'(k), 32'd6);
        @(posedge clk);
        #1;
        releaseReq(0);
        releaseReq(1);

        $display("[TB] fixed priority instance");
        ifB.req0 = 1; ifB.addr0 = 32'h00;
        ifB.req1 = 1; ifB.addr1 = 32'h04;
        nAck0 = 0;
        nAck1 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifB.ack0) nAck0++;
            if (ifB.ack1) nAck1++;
        end
        checkOutput("fp_ack0Count", 32'(nAck0), 32'd4);
        checkOutput("fp_ack1Count", 32'(nAck1), 32'd0);
        checkOutput("fp_rdata0", ifB.rdata0, 32'hA500_0000);
        ifB.req0 = 0;
        seen = 1'b0;
        waitC = 0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ifB.ack0) checkBit("fp_extraAck0", 1'b1, 1'b0);
            if (ifB.ack1) begin seen = 1'b1; waitC = c; end
        end
        checkOutput("fp_ack1Delay", 32'(waitC), 32'd2);
        checkOutput("fp_rdata1", ifB.rdata1, 32'hA500_0001);
        @(posedge clk);
        #1;
        ifB.req1 = 0;

        $display("[TB] reset during ack");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h04, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkBit("t5_ack1InRst", ifA.ack1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        releaseReq(1);
        modelReset();
        @(negedge clk);
        checkBit("t5_ack1After", ifA.ack1, 1'b0);
        checkOutput("t5_rdata1After", ifA.rdata1, 32'h0);
        @(posedge clk);
        #1;
        runPair(0, 1, 0, 0, 0, 32'h04, 0, 0, "t5", rd0, rd1);
        checkOutput("t5_rdata1", rd1, 32'd9);

        $display("[TB] misaligned write");
        runPair(0, 1, 0, 1, 0, 32'h06, 0, 32'h5A5A_5A5A, "t6w", rd0, rd1);
        runPair(1, 0, 0, 0, 32'h04, 0, 0, 0, "t6r", rd0, rd1);
`ifdef DMEM_ARB_ALIGN_CHK_EN
        checkOutput("t6_word1", rd0, 32'd9);
`else
        checkOutput("t6_word1", rd0, 32'h5A5A_5A5A);
`endif

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            runPair(!vecs[i].port, vecs[i].port, vecs[i].we, vecs[i].we,
                    vecs[i].addr, vecs[i].addr, vecs[i].wdata, vecs[i].wdata,
                    $sformatf("vec%0d", i), rd0, rd1);
            if (!vecs[i].we)
                checkOutput($sformatf("vec%0d_rdata", i), vecs[i].port ? rd1 : rd0, vecs[i].expRd);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 30; i++) begin
            bit e0, e1;
            e0 = 1'($urandom_range(0, 1));
            e1 = 1'($urandom_range(0, 1));
            if (!e0 && !e1) e0 = 1'b1;
            runPair(e0, e1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom(), $urandom(), $urandom(), $urandom(),
                    $sformatf("rnd%0d", i), rd0, rd1);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
